wb_bus_arbiter: RTL and testbench

- Shares one Wishbone classic slave port among NUM_MASTERS masters in the SoC interconnect.
- Round-robin fair: priority rotates to the master after the last owner.
- A granted master keeps the bus for its whole cycle (wbm_cyc_i high), so bursts and read-modify-write sequences stay atomic.
- Optional watchdog ends hung slave transfers with an error response.

---
 rtl/wb_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_wb_bus_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone classic arbiter: NUM_MASTERS masters share one slave port,
// and the owner keeps the bus while it holds cyc. Optional watchdog: WB_ARB_TIMEOUT_EN.
module wb_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int SW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]      wbm_we_i,
  input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
  output logic [DW-1:0]               wbm_dat_o,
  output logic [NUM_MASTERS-1:0]      wbm_ack_o,
  output logic [NUM_MASTERS-1:0]      wbm_err_o,
  output logic [AW-1:0]               wbs_adr_o,
  output logic [DW-1:0]               wbs_dat_o,
  output logic [DW/8-1:0]             wbs_sel_o,
  output logic                        wbs_we_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  input  logic [DW-1:0]               wbs_dat_i,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  output logic [NUM_MASTERS-1:0]      grant,
  output logic [SW-1:0]               select,
  output logic                        active,
  output logic                        timeout
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t                 state, state_nxt;
  logic [NUM_MASTERS-1:0] grant_nxt;
  logic [SW-1:0]          select_nxt, last, last_nxt, winner;
  logic [SW:0]            cand;
  logic                   found;
  logic                   owner_cyc;
  logic                   wd_fire;

  assign owner_cyc = wbm_cyc_i[select];

  // First requester after the previous owner, wrapping modulo NUM_MASTERS.
  always_comb begin
    found  = 1'b0;
    winner = last;
    cand   = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = {1'b0, last} + (SW+1)'(i);
      if (cand >= (SW+1)'(NUM_MASTERS))
        cand = cand - (SW+1)'(NUM_MASTERS);
      if (!found && wbm_cyc_i[cand[SW-1:0]]) begin
        found  = 1'b1;
        winner = cand[SW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    select_nxt = select;
    last_nxt   = last;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt         = OWN;
          grant_nxt         = '0;
          grant_nxt[winner] = 1'b1;
          select_nxt        = winner;
          last_nxt          = winner;
        end
      end
      OWN: begin
        if (!owner_cyc) begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      select <= '0;
      last   <= SW'(NUM_MASTERS - 1);
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      select <= select_nxt;
      last   <= last_nxt;
    end
  end

  assign active    = (state == OWN);
  assign wbs_adr_o = wbm_adr_i[select*AW +: AW];
  assign wbs_dat_o = wbm_dat_i[select*DW +: DW];
  assign wbs_sel_o = wbm_sel_i[select*(DW/8) +: DW/8];
  assign wbs_we_o  = wbm_we_i[select];
  assign wbs_cyc_o = active & owner_cyc;
  assign wbs_stb_o = wbs_cyc_o & wbm_stb_i[select];
  assign wbm_dat_o = wbs_dat_i;

  // grant is all-zero while idle, so stray slave responses never reach a master.
  assign wbm_ack_o = grant & {NUM_MASTERS{wbs_ack_i & ~wd_fire}};
  assign wbm_err_o = grant & {NUM_MASTERS{wbs_err_i | wd_fire}};

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wd_cnt;

  assign wd_fire = wbs_stb_o && (wd_cnt == CW'(TIMEOUT_CYCLES));
  assign timeout = wd_fire;

  always_ff @(posedge clk) begin
    if (rst || !wbs_stb_o || wbs_ack_i || wbs_err_i || wd_fire)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: vector table, directed corner sequences,
// and randomized traffic against a behavioural owner/pointer model.
module tb_wb_bus_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 2;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [N*AW-1:0]     wbm_adr_i;
  logic [N*DW-1:0]     wbm_dat_i;
  logic [N*DW/8-1:0]   wbm_sel_i;
  logic [N-1:0]        wbm_we_i, wbm_cyc_i, wbm_stb_i;
  logic [DW-1:0]       wbm_dat_o;
  logic [N-1:0]        wbm_ack_o, wbm_err_o;
  logic [AW-1:0]       wbs_adr_o;
  logic [DW-1:0]       wbs_dat_o;
  logic [DW/8-1:0]     wbs_sel_o;
  logic                wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [DW-1:0]       wbs_dat_i;
  logic                wbs_ack_i, wbs_err_i;
  logic [N-1:0]        grant;
  logic [SW-1:0]       select;
  logic                active, timeout;

  wb_bus_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .grant(grant), .select(select), .active(active), .timeout(timeout)
  );

  typedef struct {
    logic [3:0] cyc;
    logic       ack;
    logic [3:0] e_grant;
    logic       e_active;
    logic       e_scyc;
    logic [3:0] e_ack;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_owner, m_last, m_age;
  logic m_sstb, m_fire;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Owner is -1 when the bus is free; last is the previous owner index.
  task automatic sample();
    int   o;
    logic act;
    logic e_scyc;
    #3;
    act    = (m_owner >= 0);
    o      = act ? m_owner : 0;
    e_scyc = act && wbm_cyc_i[o];
    m_sstb = e_scyc && wbm_stb_i[o];
`ifdef WB_ARB_TIMEOUT_EN
    m_fire = m_sstb && (m_age == TO);
`else
    m_fire = 1'b0;
`endif
    chk("active", 64'(active), 64'(act));
    chk("grant", 64'(grant), act ? (64'd1 << o) : 64'd0);
    if (act) begin
      chk("select", 64'(select), 64'(o));
      chk("wbs_adr", 64'(wbs_adr_o), 64'(wbm_adr_i[o*AW +: AW]));
      chk("wbs_dat", 64'(wbs_dat_o), 64'(wbm_dat_i[o*DW +: DW]));
      chk("wbs_sel", 64'(wbs_sel_o), 64'(wbm_sel_i[o*(DW/8) +: DW/8]));
      chk("wbs_we", 64'(wbs_we_o), 64'(wbm_we_i[o]));
    end
    chk("wbs_cyc", 64'(wbs_cyc_o), 64'(e_scyc));
    chk("wbs_stb", 64'(wbs_stb_o), 64'(m_sstb));
    chk("wbm_ack", 64'(wbm_ack_o), act ? (64'(wbs_ack_i && !m_fire) << o) : 64'd0);
    chk("wbm_err", 64'(wbm_err_o), act ? (64'(wbs_err_i || m_fire) << o) : 64'd0);
    chk("wbm_dat", 64'(wbm_dat_o), 64'(wbs_dat_i));
    chk("timeout", 64'(timeout), 64'(m_fire));
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_owner = -1;
      m_last  = N - 1;
      m_age   = 0;
    end else begin
      if (m_sstb && !wbs_ack_i && !wbs_err_i && !m_fire) m_age++;
      else m_age = 0;
      if (m_owner < 0) begin
        for (int i = 1; i <= N; i++) begin
          int c;
          c = (m_last + i) % N;
          if (wbm_cyc_i[c]) begin
            m_owner = c;
            m_last  = c;
            break;
          end
        end
      end else if (!wbm_cyc_i[m_owner]) begin
        m_owner = -1;
      end
    end
    #1;
  endtask

  task automatic drive(input logic [3:0] cyc, input logic [3:0] stb, input logic ack);
    wbm_cyc_i = cyc;
    wbm_stb_i = stb;
    wbs_ack_i = ack;
    wbs_err_i = 1'b0;
  endtask

  vec_t tbl [13];
  int   exp_rr [6];
  int   rr_sel [$];
  int   rr_gap [$];

  initial begin
    int         gap, first_t, hits, acks2;
    logic       prev_act;
    logic [3:0] drop;

    tbl = '{
      '{4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000},
      '{4'b1010, 1'b1, 4'b0010, 1'b1, 1'b1, 4'b0010},
      '{4'b1000, 1'b0, 4'b0010, 1'b1, 1'b0, 4'b0000},
      '{4'b1000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000},
      '{4'b1000, 1'b1, 4'b1000, 1'b1, 1'b1, 4'b1000},
      '{4'b0000, 1'b0, 4'b1000, 1'b1, 1'b0, 4'b0000},
      '{4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000},
      '{4'b0101, 1'b1, 4'b0001, 1'b1, 1'b1, 4'b0001},
      '{4'b0100, 1'b0, 4'b0001, 1'b1, 1'b0, 4'b0000},
      '{4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000},
      '{4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 4'b0100},
      '{4'b0000, 1'b0, 4'b0100, 1'b1, 1'b0, 4'b0000},
      '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000}
    };
    exp_rr = '{0, 2, 3, 0, 2, 3};

    rst = 1'b1;
    wbm_we_i = '1;
    wbm_sel_i = '1;
    wbs_dat_i = 32'hCAFE_0001;
    for (int k = 0; k < N; k++) begin
      wbm_adr_i[k*AW +: AW] = 32'h100 * k;
      wbm_dat_i[k*DW +: DW] = 32'h1111_1111 * k;
    end
    wbm_dat_i[1*DW +: DW] = 32'hDEAD_BEEF;
    drive(4'b0000, 4'b0000, 1'b0);
    m_sstb = 1'b0;
    m_fire = 1'b0;
    repeat (2) @(posedge clk);
    m_owner = -1;
    m_last  = N - 1;
    m_age   = 0;
    #1;
    rst = 1'b0;

    // Idle after reset
    for (int c = 0; c < 10; c++) begin
      sample();
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_select", 64'(select), 64'd0);
      chk("rst_active", 64'(active), 64'd0);
      chk("rst_wbs_cyc", 64'(wbs_cyc_o), 64'd0);
      advance();
    end

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].cyc, tbl[i].cyc, tbl[i].ack);
      sample();
      chk("tbl_grant", 64'(grant), 64'(tbl[i].e_grant));
      chk("tbl_active", 64'(active), 64'(tbl[i].e_active));
      chk("tbl_wbs_cyc", 64'(wbs_cyc_o), 64'(tbl[i].e_scyc));
      chk("tbl_ack", 64'(wbm_ack_o), 64'(tbl[i].e_ack));
      if (i == 1) begin
        chk("tbl_m1_adr", 64'(wbs_adr_o), 64'h100);
        chk("tbl_m1_dat", 64'(wbs_dat_o), 64'hDEAD_BEEF);
        chk("tbl_m1_we", 64'(wbs_we_o), 64'd1);
      end
      advance();
    end

    // Round robin among 0,2,3 with one dropped-cyc cycle after each transfer
    rst = 1'b1; drive(4'b0000, 4'b0000, 1'b0); sample(); advance(); rst = 1'b0;
    gap = 0; prev_act = 1'b0; drop = 4'b0000;
    for (int c = 0; c < 24; c++) begin
      wbm_cyc_i = 4'b1101 & ~drop;
      wbm_stb_i = wbm_cyc_i;
      wbs_ack_i = (m_owner >= 0) && wbm_cyc_i[(m_owner >= 0) ? m_owner : 0];
      sample();
      if (active && !prev_act) begin
        rr_sel.push_back(int'(select));
        rr_gap.push_back(gap);
        gap = 0;
      end
      if (!active) gap++;
      prev_act = active;
      drop = wbs_ack_i ? 4'(1 << m_owner) : 4'b0000;
      advance();
    end
    chk("rr_count_ok", 64'(rr_sel.size() >= 6), 64'd1);
    for (int i = 0; i < 6 && i < rr_sel.size(); i++) begin
      chk("rr_order", 64'(rr_sel[i]), 64'(exp_rr[i]));
      chk("rr_idle_gap", 64'(rr_gap[i]), 64'd1);
    end
    repeat (2) begin drive(4'b0000, 4'b0000, 1'b0); sample(); advance(); end

    // Master 2 burst while master 0 waits
    drive(4'b0100, 4'b0100, 1'b0); sample(); advance();
    acks2 = 0;
    for (int b = 0; b < 4; b++) begin
      drive(4'b0101, 4'b0101, 1'b1);
      sample();
      chk("burst_grant", 64'(grant), 64'b0100);
      chk("burst_ack", 64'(wbm_ack_o), 64'b0100);
      if (wbm_ack_o[2]) acks2++;
      advance();
    end
    chk("burst_beats", 64'(acks2), 64'd4);
    drive(4'b0001, 4'b0001, 1'b0); sample(); advance();
    sample(); chk("burst_gap", 64'(active), 64'd0); advance();
    sample(); chk("burst_next", 64'(grant), 64'b0001); advance();
    repeat (2) begin drive(4'b0000, 4'b0000, 1'b0); sample(); advance(); end

    // Reset while master 3 owns with stb high
    drive(4'b1000, 4'b1000, 1'b0); sample(); advance();
    sample(); chk("pre_rst_stb", 64'(wbs_stb_o), 64'd1); advance();
    rst = 1'b1; sample(); advance(); rst = 1'b0;
    drive(4'b1001, 4'b1001, 1'b1);
    sample();
    chk("post_rst_active", 64'(active), 64'd0);
    chk("post_rst_cyc", 64'(wbs_cyc_o), 64'd0);
    chk("post_rst_ack", 64'(wbm_ack_o), 64'd0);
    advance();
    drive(4'b1001, 4'b1001, 1'b0);
    sample(); chk("post_rst_winner", 64'(grant), 64'b0001); advance();
    repeat (2) begin drive(4'b0000, 4'b0000, 1'b0); sample(); advance(); end

    // Hung slave on master 1
    drive(4'b0010, 4'b0010, 1'b0); sample(); advance();
    first_t = -1; hits = 0;
    for (int t = 0; t < 20; t++) begin
      sample();
      if (timeout) begin
        hits++;
        if (first_t < 0) first_t = t;
      end
      advance();
    end
`ifdef WB_ARB_TIMEOUT_EN
    chk("wd_first_fire", 64'(first_t), 64'(TO));
    chk("wd_fire_count", 64'(hits), 64'd2);
`else
    chk("wd_absent_hits", 64'(hits), 64'd0);
`endif
    repeat (2) begin drive(4'b0000, 4'b0000, 1'b0); sample(); advance(); end

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 3) == 0) wbm_cyc_i[k] = ~wbm_cyc_i[k];
      wbm_stb_i = 4'($urandom);
      wbm_we_i  = 4'($urandom);
      wbm_sel_i = 16'($urandom);
      for (int k = 0; k < N; k++) begin
        wbm_adr_i[k*AW +: AW] = $urandom;
        wbm_dat_i[k*DW +: DW] = $urandom;
      end
      wbs_dat_i = $urandom;
      wbs_ack_i = ($urandom_range(0, 2) == 0);
      wbs_err_i = ($urandom_range(0, 7) == 0);
      sample();
      advance();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
